// File: rtl/wb_write_queue.sv
// Dual-issue writeback queue: accepts up to two register writes per cycle, retires one per cycle.
// Define WBQ_BYPASS_EN to add forwarding of queued data to two read ports.
module wb_write_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wbValid0,
    input  logic                     wbValid1,
    input  logic [4:0]               wbReg0,
    input  logic [4:0]               wbReg1,
    input  logic [31:0]              wbData0,
    input  logic [31:0]              wbData1,
    output logic                     ready,
    output logic                     we,
    output logic [4:0]               writeRegister,
    output logic [31:0]              writeData,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
`ifdef WBQ_BYPASS_EN
    ,
    input  logic [4:0]               readRegister1,
    input  logic [4:0]               readRegister2,
    output logic                     bypassHit1,
    output logic                     bypassHit2,
    output logic [31:0]              bypassData1,
    output logic [31:0]              bypassData2
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] tail1;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       reg_q  [DEPTH];
    logic [4:0]       reg_d  [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic             push0, push1, pop;

    // Acceptance looks only at the registered count, so a pop this cycle never frees room early.
    assign ready         = (count_q <= CNT_W'(DEPTH - 2));
    assign empty         = (count_q == '0);
    assign full          = (count_q == CNT_W'(DEPTH));
    assign we            = !empty;
    assign writeRegister = reg_q[head_q];
    assign writeData     = data_q[head_q];
    assign count         = count_q;

    always_comb begin
        // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
        reg_d  = reg_q;
        data_d = data_q;
        push0  = ready && wbValid0 && (wbReg0 != 5'd0);
        push1  = ready && wbValid1 && (wbReg1 != 5'd0);
        pop    = we;
        tail1  = tail_q + PTR_W'(push0);
        if (push0) begin
            reg_d[tail_q]  = wbReg0;
            data_d[tail_q] = wbData0;
        end
        // Slot 1 lands behind slot 0, so a same-register pair retires with slot 1's data last.
        if (push1) begin
            reg_d[tail1]  = wbReg1;
            data_d[tail1] = wbData1;
        end
        tail_d  = tail_q + PTR_W'(push0) + PTR_W'(push1);
        head_d  = head_q + PTR_W'(pop);
        count_d = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            // NOTE: the storage array is reset too, so the write port reads zero while in reset.
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                reg_q[i]  <= reg_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

`ifdef WBQ_BYPASS_EN
    logic [PTR_W-1:0] bp_idx;

    // Walk from oldest to youngest so the last match wins; the popping head is still covered.
    always_comb begin
        bypassHit1  = 1'b0;
        bypassHit2  = 1'b0;
        bypassData1 = '0;
        bypassData2 = '0;
        bp_idx      = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            bp_idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((readRegister1 != 5'd0) && (reg_q[bp_idx] == readRegister1)) begin
                    bypassHit1  = 1'b1;
                    bypassData1 = data_q[bp_idx];
                end
                if ((readRegister2 != 5'd0) && (reg_q[bp_idx] == readRegister2)) begin
                    bypassHit2  = 1'b1;
                    bypassData2 = data_q[bp_idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue with a FIFO scoreboard of expected register writes.
module tb_wb_write_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rg;
        logic [31:0] data;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wbValid0 = 1'b0, wbValid1 = 1'b0;
    logic [4:0]  wbReg0 = '0, wbReg1 = '0;
    logic [31:0] wbData0 = '0, wbData1 = '0;
    logic        ready, we, empty, full;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [$clog2(DEPTH):0] count;
`ifdef WBQ_BYPASS_EN
    logic [4:0]  readRegister1 = '0, readRegister2 = '0;
    logic        bypassHit1, bypassHit2;
    logic [31:0] bypassData1, bypassData2;
`endif

    entry_t sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    bit     acc;

    wb_write_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .wbValid0(wbValid0), .wbValid1(wbValid1),
        .wbReg0(wbReg0), .wbReg1(wbReg1),
        .wbData0(wbData0), .wbData1(wbData1),
        .ready(ready), .we(we),
        .writeRegister(writeRegister), .writeData(writeData),
        .empty(empty), .full(full), .count(count)
`ifdef WBQ_BYPASS_EN
        ,
        .readRegister1(readRegister1), .readRegister2(readRegister2),
        .bypassHit1(bypassHit1), .bypassHit2(bypassHit2),
        .bypassData1(bypassData1), .bypassData2(bypassData2)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares all status outputs and the head write against the scoreboard.
    task automatic check_state(input string tag);
        int occ;
        occ = sb.size();
        check({tag, ".count"}, 32'(count), 32'(occ));
        check({tag, ".empty"}, 32'(empty), 32'(occ == 0));
        check({tag, ".full"},  32'(full),  32'(occ == DEPTH));
        check({tag, ".ready"}, 32'(ready), 32'((DEPTH - occ) >= 2));
        check({tag, ".we"},    32'(we),    32'(occ != 0));
        if (occ != 0) begin
            check({tag, ".wreg"},  32'(writeRegister), 32'(sb[0].rg));
            check({tag, ".wdata"}, writeData, sb[0].data);
        end
    endtask

    task automatic drive(input bit v0, input logic [4:0] r0, input logic [31:0] d0,
                         input bit v1, input logic [4:0] r1, input logic [31:0] d1);
        wbValid0 = v0; wbReg0 = r0; wbData0 = d0;
        wbValid1 = v1; wbReg1 = r1; wbData1 = d1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    // One clock edge: the model retires the head and accepts requests only when it has room for two.
    task automatic tick(output bit accepted);
        bit rdy_m;
        rdy_m = (DEPTH - sb.size()) >= 2;
        @(posedge clk);
        if (sb.size() != 0) void'(sb.pop_front());
        accepted = rdy_m;
        if (rdy_m && wbValid0 && (wbReg0 != 5'd0)) sb.push_back('{rg: wbReg0, data: wbData0});
        if (rdy_m && wbValid1 && (wbReg1 != 5'd0)) sb.push_back('{rg: wbReg1, data: wbData1});
        #1;
    endtask

    // Producer holds the request until the queue takes it, within a bounded number of cycles.
    task automatic push_held(input string tag,
                             input logic [4:0] r0, input logic [31:0] d0,
                             input logic [4:0] r1, input logic [31:0] d1);
        bit got;
        got = 1'b0;
        drive(1'b1, r0, d0, 1'b1, r1, d1);
        for (int i = 0; i < 8 && !got; i++) begin
            tick(got);
            check_state(tag);
        end
        check({tag, ".accepted"}, 32'(got), 32'd1);
        idle();
    endtask

    task automatic drain(input string tag);
        bit a;
        for (int i = 0; i < DEPTH + 2 && sb.size() != 0; i++) begin
            tick(a);
            check_state(tag);
        end
        check({tag, ".drained"}, 32'(empty), 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check_state("reset");
        check("reset.wreg", 32'(writeRegister), 32'd0);
        check("reset.wdata", writeData, 32'd0);
`ifdef WBQ_BYPASS_EN
        readRegister1 = 5'd0;
        check("reset.hit1", 32'(bypassHit1), 32'd0);
        check("reset.hit2", 32'(bypassHit2), 32'd0);
`endif
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        check_state("post_reset");

        // Single push, one-cycle latency
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        tick(acc);
        idle();
        check_state("single");
        check("single.we", 32'(we), 32'd1);
        check("single.wreg", 32'(writeRegister), 32'd5);
        check("single.wdata", writeData, 32'hDEADBEEF);
        tick(acc);
        check_state("single_done");
        check("single.empty", 32'(empty), 32'd1);

        // Same-register pair retires in order
        drive(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
        tick(acc);
        idle();
        check_state("pair0");
        check("pair0.count", 32'(count), 32'd2);
        check("pair0.wdata", writeData, 32'h11);
        tick(acc);
        check_state("pair1");
        check("pair1.count", 32'(count), 32'd1);
        check("pair1.wdata", writeData, 32'h22);
        tick(acc);
        check_state("pair2");
        check("pair2.count", 32'(count), 32'd0);

        // Register-0 request is dropped
        drive(1'b1, 5'd0, 32'h99, 1'b1, 5'd3, 32'h33);
        tick(acc);
        idle();
        check_state("r0drop");
        check("r0drop.count", 32'(count), 32'd1);
        check("r0drop.wreg", 32'(writeRegister), 32'd3);
        check("r0drop.wdata", writeData, 32'h33);
        tick(acc);
        check_state("r0drop_done");

        // Occupancy boundary: back-to-back pairs, then a held pair that must wait
        push_held("bb0", 5'd1, 32'hA1, 5'd2, 32'hA2);
        check("bb0.count", 32'(count), 32'd2);
        push_held("bb1", 5'd3, 32'hA3, 5'd4, 32'hA4);
        check("bb1.count", 32'(count), 32'd3);
        check("bb1.ready", 32'(ready), 32'd0);
        drive(1'b1, 5'd5, 32'hA5, 1'b1, 5'd6, 32'hA6);
        tick(acc);
        check_state("held0");
        check("held0.count", 32'(count), 32'd2);
        check("held0.wreg", 32'(writeRegister), 32'd3);
        tick(acc);
        idle();
        check_state("held1");
        check("held1.count", 32'(count), 32'd3);
        drain("wrap");

`ifdef WBQ_BYPASS_EN
        // Forwarding picks the youngest match; register 0 never hits
        drive(1'b1, 5'd9, 32'hA, 1'b1, 5'd9, 32'hB);
        readRegister1 = 5'd9;
        readRegister2 = 5'd0;
        tick(acc);
        idle();
        check_state("bp0");
        check("bp0.hit1", 32'(bypassHit1), 32'd1);
        check("bp0.data1", bypassData1, 32'hB);
        check("bp0.hit2", 32'(bypassHit2), 32'd0);
        check("bp0.data2", bypassData2, 32'd0);
        readRegister2 = 5'd12;
        #1;
        check("bp0.miss_hit2", 32'(bypassHit2), 32'd0);
        tick(acc);
        check_state("bp1");
        check("bp1.hit1", 32'(bypassHit1), 32'd1);
        check("bp1.data1", bypassData1, 32'hB);
        tick(acc);
        check_state("bp2");
        check("bp2.hit1", 32'(bypassHit1), 32'd0);
        check("bp2.data1", bypassData1, 32'd0);
        readRegister1 = 5'd0;
        readRegister2 = 5'd0;
`endif

        // Asynchronous reset with entries in flight
        push_held("pre_rst0", 5'd10, 32'hB0, 5'd11, 32'hB1);
        push_held("pre_rst1", 5'd12, 32'hB2, 5'd13, 32'hB3);
        check("pre_rst.count", 32'(count), 32'd3);
        #2;
        rst = 1'b0;
        #1;
        check("arst.we", 32'(we), 32'd0);
        check("arst.count", 32'(count), 32'd0);
        check("arst.wreg", 32'(writeRegister), 32'd0);
        check("arst.wdata", writeData, 32'd0);
        sb.delete();
        check_state("arst");
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b1, 5'd20, 32'hCAFE, 1'b0, 5'd0, 32'd0);
        tick(acc);
        idle();
        check_state("post_arst");
        check("post_arst.wreg", 32'(writeRegister), 32'd20);
        check("post_arst.wdata", writeData, 32'hCAFE);
        drain("post_arst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
